// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: operation and FSM state encodings.
// No ports; imported by muldiv_step and muldiv_unit.
// Helper functions decode the op into its signed/divide properties.
package muldiv_pkg;

  // Encoding matches the 2-bit op input: bit 1 selects divide, bit 0 selects unsigned.
  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  function automatic logic op_is_div(input op_e o);
    return (o == DIV) || (o == DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return (o == MULT) || (o == DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath: add-shift (multiply) or restoring subtract-shift (divide).
// Latency: purely combinational, zero cycles; no backpressure (caller decides when to register acc_o).
// Ports: is_div_i selects divide; acc_i/acc_o = {upper, lower} working register; opnd_i = multiplicand or divisor.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 is_div_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     opnd_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH-1:0] upper;
  logic [WIDTH-1:0] lower;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;

  always_comb begin
    upper = acc_i[2*WIDTH-1:WIDTH];
    lower = acc_i[WIDTH-1:0];

    // Multiply: upper holds the partial product, lower the not-yet-consumed multiplier bits.
    // The carry out of the add becomes the new top bit as the whole register shifts right.
    sum = {1'b0, upper} + (lower[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});

    // Divide: upper is the partial remainder, lower the dividend bits shifting into quotient bits.
    // trial[WIDTH] is the borrow: set means the divisor does not fit, so the remainder is kept.
    trial = {upper, lower[WIDTH-1]} - {1'b0, opnd_i};

    if (is_div_i) begin
      if (!trial[WIDTH]) begin
        acc_o = {trial[WIDTH-1:0], lower[WIDTH-2:0], 1'b1};
      end else begin
        // Restore path only occurs when upper[WIDTH-1]==0, so dropping it loses nothing.
        acc_o = {upper[WIDTH-2:0], lower[WIDTH-1], lower[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = {sum, lower[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU) with MTHI/MTLO writes.
// Latency: WIDTH+2 cycles start-to-done (1 cycle for divide by zero); start is ignored while busy.
// Ports: clk/rst (sync, active-high); start/op/a/b request; hi_we/lo_we/wdata direct writes;
//        busy/done/div_by_zero status; hi/lo result registers.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [WIDTH-1:0]  wdata,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 sign_a_q, sign_a_d;
  logic                 sign_b_q, sign_b_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 dbz_q, dbz_d;

  op_e                  op_in;
  logic                 busy_w;
  logic                 can_accept;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [2*WIDTH-1:0]   step_acc;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     rem;

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div_i (op_is_div(op_q)),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc)
  );

  assign busy_w      = (state_q == RUN) || (state_q == FIX);
  assign busy        = busy_w;
  assign done        = (state_q == DONE);
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

  // Operand magnitudes: signed ops work on absolute values; the most-negative value
  // maps onto itself, which is still the correct unsigned magnitude.
  always_comb begin
    op_in = op_e'(op);
    a_mag = (op_is_signed(op_in) && a[WIDTH-1]) ? -a : a;
    b_mag = (op_is_signed(op_in) && b[WIDTH-1]) ? -b : b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    can_accept = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d    = IDLE;
        can_accept = start;
        if (start) begin
          state_d = (op_is_div(op_in) && (b == '0)) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath next-state. Ordering matters: the MTHI/MTLO write is applied first so that
  // a divide-by-zero result accepted on the same edge overwrites it.
  always_comb begin
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    prod     = acc_q;
    quo      = acc_q[WIDTH-1:0];
    rem      = acc_q[2*WIDTH-1:WIDTH];

    if (!busy_w) begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
    end

    if (can_accept) begin
      op_d     = op_in;
      cnt_d    = '0;
      dbz_d    = 1'b0;
      sign_a_d = op_is_signed(op_in) && a[WIDTH-1];
      sign_b_d = op_is_signed(op_in) && b[WIDTH-1];
      // Both multiply and divide start with upper=0 and the a-magnitude in the lower half.
      acc_d    = {{WIDTH{1'b0}}, a_mag};
      opnd_d   = b_mag;
      if (op_is_div(op_in) && (b == '0)) begin
        hi_d  = a;
        lo_d  = '1;
        dbz_d = 1'b1;
      end
    end else if (state_q == RUN) begin
      acc_d = step_acc;
      cnt_d = cnt_q + CNT_W'(1);
    end else if (state_q == FIX) begin
      if (op_is_div(op_q)) begin
        // Quotient negated when signs differ; remainder follows the dividend's sign.
        // Most-negative / -1 falls out naturally as lo=most-negative, hi=0.
        if (sign_a_q ^ sign_b_q) quo = -acc_q[WIDTH-1:0];
        if (sign_a_q)            rem = -acc_q[2*WIDTH-1:WIDTH];
        lo_d = quo;
        hi_d = rem;
      end else begin
        if (sign_a_q ^ sign_b_q) prod = -acc_q;
        hi_d = prod[2*WIDTH-1:WIDTH];
        lo_d = prod[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= MULT;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

endmodule
